// File: rtl/keccak_round_ctrl_if.sv
// Host/PRNG/datapath-facing control bundle of the masked Keccak round sequencer.
// The slave side is the sequencer; the master side drives start and the PRNG valid.
interface keccak_round_ctrl_if #(
    parameter int unsigned RW = 5
) ();
    logic          start;
    logic          busy;
    logic          done;
    logic          load_sel;
    logic          state_en;
    logic          exp_en;
    logic          rnd_ready;
    logic          rnd_valid;
    logic [RW-1:0] round;
    logic [63:0]   rc;

    modport master (
        output start,
        output rnd_valid,
        input  busy,
        input  done,
        input  load_sel,
        input  state_en,
        input  exp_en,
        input  rnd_ready,
        input  round,
        input  rc
    );

    modport slave (
        input  start,
        input  rnd_valid,
        output busy,
        output done,
        output load_sel,
        output state_en,
        output exp_en,
        output rnd_ready,
        output round,
        output rc
    );
endinterface

// File: rtl/keccak_round_ctrl.sv
// Round sequencer for a two-cycle-per-round masked Keccak-f[1600] datapath:
// EXP registers the share expansion when fresh masks are valid, COMP compresses and applies iota.
module keccak_round_ctrl #(
    parameter int unsigned D  = 4,
    parameter int unsigned NR = 24,
    parameter int unsigned RW = 5
) (
    input  logic                clk,
    input  logic                rst,
    keccak_round_ctrl_if.slave  bus
);

    // An illegal configuration never leaves IDLE rather than running a malformed permutation.
    localparam bit ParamOk = (D >= 1) && (NR >= 1) && (NR <= 24) && ((2 ** RW) >= NR);
    localparam logic [RW-1:0] LastRound = RW'(NR - 1);
    localparam logic [7:0]    LfsrSeed  = 8'h01;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StExp,
        StComp,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [7:0]    lfsr_q, lfsr_d;

    logic [7:0]    lfsr_walk;
    logic [7:0]    lfsr_adv;
    logic [63:0]   rc_round;

    // Galois form of x^8+x^6+x^5+x^4+1; bit 0 is the generator output.
    function automatic logic [7:0] lfsr_step(logic [7:0] s);
        logic [7:0] shifted;
        shifted = {s[6:0], 1'b0};
        return s[7] ? (shifted ^ 8'h71) : shifted;
    endfunction

    // Seven generator outputs per round land on rc bits 0,1,3,7,15,31,63.
    always_comb begin
        lfsr_walk = lfsr_q;
        rc_round  = '0;
        for (int j = 0; j < 7; j++) begin
            rc_round[6'((1 << j) - 1)] = lfsr_walk[0];
            lfsr_walk = lfsr_step(lfsr_walk);
        end
        lfsr_adv = lfsr_walk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= '0;
            lfsr_q  <= LfsrSeed;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        lfsr_d  = lfsr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && ParamOk) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                round_d = '0;
                lfsr_d  = LfsrSeed;
                state_d = StExp;
            end
            StExp: begin
                if (bus.rnd_valid) begin
                    state_d = StComp;
                end
            end
            StComp: begin
                if (round_q == LastRound) begin
                    state_d = StDone;
                end else begin
                    round_d = round_q + RW'(1);
                    lfsr_d  = lfsr_adv;
                    state_d = StExp;
                end
            end
            StDone: begin
                round_d = '0;
                lfsr_d  = LfsrSeed;
                state_d = StIdle;
            end
            default: begin
                round_d = '0;
                lfsr_d  = LfsrSeed;
                state_d = StIdle;
            end
        endcase
    end

    // Everything except exp_en is decoded from registered state only.
    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.load_sel  = 1'b0;
        bus.state_en  = 1'b0;
        bus.rnd_ready = 1'b0;
        bus.exp_en    = 1'b0;
        bus.rc        = '0;
        unique case (state_q)
            StIdle: begin
            end
            StLoad: begin
                bus.busy     = 1'b1;
                bus.load_sel = 1'b1;
                bus.state_en = 1'b1;
            end
            StExp: begin
                bus.busy      = 1'b1;
                bus.rnd_ready = 1'b1;
                bus.exp_en    = bus.rnd_valid;
            end
            StComp: begin
                bus.busy     = 1'b1;
                bus.state_en = 1'b1;
                bus.rc       = rc_round;
            end
            StDone: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.round = round_q;

endmodule
